// File: rtl/tdm_demux_8ch.sv
// Eight-channel TDM demultiplexer: routes a 1-bit-per-slot serial stream into
// an 8-bit frame word, tracks frame alignment and flags sync errors.
module tdm_demux_8ch (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       din,
   input  logic       din_valid,
   input  logic       frame_sync,
   output logic [7:0] dout,
   output logic       frame_valid,
   output logic [7:0] chan_en,
   output logic [2:0] slot,
   output logic       locked,
   output logic       sync_err
);

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned SLOT_W = 3;
   localparam int unsigned HOLD_W = NUM_CH - 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [HOLD_W-1:0]   hold, hold_nxt;
   logic [SLOT_W-1:0]   slot_nxt;
   logic [NUM_CH-1:0]   dout_nxt;
   logic [NUM_CH-1:0]   chan_en_nxt;
   logic                frame_valid_nxt;
   logic                sync_err_nxt;
   logic                locked_nxt;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         hold        <= '0;
         slot        <= '0;
         dout        <= '0;
         chan_en     <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         locked      <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold        <= hold_nxt;
         slot        <= slot_nxt;
         dout        <= dout_nxt;
         chan_en     <= chan_en_nxt;
         frame_valid <= frame_valid_nxt;
         sync_err    <= sync_err_nxt;
         locked      <= locked_nxt;
      end
   end

   // Next-state and output decode; non-beat cycles keep state and clear pulses
   always_comb begin
      state_nxt       = state;
      hold_nxt        = hold;
      slot_nxt        = slot;
      dout_nxt        = dout;
      chan_en_nxt     = '0;
      frame_valid_nxt = 1'b0;
      sync_err_nxt    = 1'b0;

      if (din_valid) begin
         unique case (state)
            HUNT: begin
               if (frame_sync) begin
                  hold_nxt[0] = din;
                  slot_nxt    = SLOT_W'(1);
                  chan_en_nxt = NUM_CH'(1);
                  state_nxt   = LOCKED;
               end
            end
            LOCKED: begin
               if (frame_sync) begin
                  // Sync anywhere but slot 0 abandons the partial frame and restarts
                  sync_err_nxt = (slot != '0);
                  hold_nxt[0]  = din;
                  slot_nxt     = SLOT_W'(1);
                  chan_en_nxt  = NUM_CH'(1);
               end else if (slot == '0) begin
                  sync_err_nxt = 1'b1;
                  slot_nxt     = '0;
                  state_nxt    = HUNT;
               end else if (slot == LAST_SLOT) begin
                  dout_nxt        = {din, hold};
                  frame_valid_nxt = 1'b1;
                  chan_en_nxt     = NUM_CH'(1) << slot;
                  slot_nxt        = '0;
               end else begin
                  hold_nxt[slot] = din;
                  chan_en_nxt    = NUM_CH'(1) << slot;
                  slot_nxt       = slot + SLOT_W'(1);
               end
            end
            default: state_nxt = HUNT;
         endcase
      end

      locked_nxt = (state_nxt == LOCKED);
   end

endmodule
